// File: rtl/inc_chain_arb.sv
`timescale 1ns/1ps
// inc_chain_arb: round-robin front end for two valid/ready sources feeding a
// rigid, globally stalled chain of STAGES slots that each add 1 modulo 2^W.
module inc_chain_arb #(
  parameter int W      = 3,
  parameter int STAGES = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_id,
  input  logic         out_ready,
  output logic         busy
);

  logic [STAGES-1:0]        valid_reg, valid_next;
  logic [STAGES-1:0][W-1:0] data_reg, data_next;
  logic [STAGES-1:0]        id_reg, id_next;
  logic                     ptr_reg, ptr_next;
  logic                     advance, grant0, grant1;
  logic                     slot0_valid, slot0_id;
  logic [W-1:0]             slot0_data;

  assign out_valid = valid_reg[STAGES-1];
  assign out_data  = data_reg[STAGES-1];
  assign out_id    = id_reg[STAGES-1];
  assign busy      = |valid_reg;

  // Only a held result in the last slot stalls the chain; bubbles never do.
  assign advance    = !(out_valid && !out_ready);
  assign req0_ready = advance && (!ptr_reg || !req1_valid);
  assign req1_ready = advance && (ptr_reg || !req0_valid);
  assign grant0     = req0_valid && req0_ready;
  assign grant1     = req1_valid && req1_ready;

  // Bubbles enter with zero data/id so slot contents stay deterministic.
  always_comb begin
    slot0_valid = grant0 || grant1;
    slot0_data  = '0;
    slot0_id    = 1'b0;
    ptr_next    = ptr_reg;
    if (grant0) begin
      slot0_data = req0_data + W'(1);
      ptr_next   = 1'b1;
    end else if (grant1) begin
      slot0_data = req1_data + W'(1);
      slot0_id   = 1'b1;
      ptr_next   = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign valid_next[gi] = slot0_valid;
        assign data_next[gi]  = slot0_data;
        assign id_next[gi]    = slot0_id;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign data_next[gi]  = data_reg[gi-1] + W'(1);
        assign id_next[gi]    = id_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= '0;
      data_reg  <= '0;
      id_reg    <= '0;
      ptr_reg   <= 1'b0;
    end else if (advance) begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_inc_chain_arb.sv
`timescale 1ns/1ps
// Bench for inc_chain_arb: queue-of-words reference model checked every cycle,
// plus directed scenarios with hand-computed result lists.
module tb_inc_chain_arb;
  localparam int W      = 3;
  localparam int STAGES = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req0_valid, req1_valid, out_ready;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, out_valid, out_id, busy;
  logic [W-1:0] out_data;

  inc_chain_arb #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word waits for STAGES advancing edges.
  typedef struct {
    bit           id;
    logic [W-1:0] data;
    int           age;
  } word_t;
  word_t q[$];
  bit    m_ptr = 1'b0;

  function automatic logic [W-1:0] plus_stages(input logic [W-1:0] d);
    return W'(int'(d) + STAGES);
  endfunction
  function automatic bit m_valid();
    return q.size() > 0 && q[0].age == STAGES;
  endfunction
  function automatic bit m_adv();
    return !(m_valid() && !out_ready);
  endfunction
  function automatic bit m_r0();
    return m_adv() && (m_ptr == 1'b0 || !req1_valid);
  endfunction
  function automatic bit m_r1();
    return m_adv() && (m_ptr == 1'b1 || !req0_valid);
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      q.delete();
      m_ptr = 1'b0;
    end else if (m_adv()) begin
      bit g0, g1;
      g0 = req0_valid && m_r0();
      g1 = req1_valid && m_r1();
      if (m_valid()) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (g0) begin
        q.push_back('{1'b0, plus_stages(req0_data), 1});
        m_ptr = 1'b1;
      end else if (g1) begin
        q.push_back('{1'b1, plus_stages(req1_data), 1});
        m_ptr = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("out_valid", out_valid, m_valid());
      if (m_valid()) begin
        chk("out_data", out_data, q[0].data);
        chk("out_id", out_id, q[0].id);
      end
      chk("busy", busy, q.size() != 0);
      chk("req0_ready", req0_ready, m_r0());
      chk("req1_ready", req1_ready, m_r1());
    end
  end

  // Log of output handshakes actually seen from the DUT.
  bit           obs_id[$];
  logic [W-1:0] obs_data[$];
  int           obs_cyc[$];
  bit           exp_id[$];
  logic [W-1:0] exp_data[$];
  int           pcount = 0;

  initial forever begin
    @(posedge clk);
    pcount++;
    cyc++;
    if (rstn && out_valid && out_ready) begin
      obs_id.push_back(out_id);
      obs_data.push_back(out_data);
      obs_cyc.push_back(pcount);
    end
  end

  task automatic expect_word(input bit id, input logic [W-1:0] d);
    exp_id.push_back(id);
    exp_data.push_back(d);
  endtask

  task automatic verify_obs(input string name);
    chk($sformatf("%s_count", name), obs_id.size(), exp_id.size());
    for (int i = 0; i < exp_id.size() && i < obs_id.size(); i++) begin
      chk($sformatf("%s_id%0d", name, i), obs_id[i], exp_id[i]);
      chk($sformatf("%s_data%0d", name, i), obs_data[i], exp_data[i]);
    end
    obs_id.delete(); obs_data.delete(); obs_cyc.delete();
    exp_id.delete(); exp_data.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push1(input bit id, input logic [W-1:0] d, output int e);
    bit took;
    took = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int i = 0; i < 20 && !took; i++) begin
      @(posedge clk);
      took = id ? req1_ready : req0_ready;
      #1;
    end
    e = cyc;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("push_accept", took, 1);
  endtask

  task automatic drain();
    repeat (STAGES + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, acc;
    bit found;
    rstn = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 1);
    chk("rst_req1_ready", req1_ready, 1);
    rstn = 1'b1;

    // Single word: 1 -> 6 after accept edge + 4, for one cycle.
    push1(1'b0, 3'd1, e);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    chk("single_seen", found, 1);
    chk("single_latency", cyc - e, STAGES - 1);
    chk("single_data", out_data, 6);
    chk("single_id", out_id, 0);
    @(negedge clk);
    chk("single_one_cycle", out_valid, 0);
    @(posedge clk); #1;
    expect_word(1'b0, 3'd6);
    verify_obs("single");

    // Wrap: 7 -> 4 and 3 -> 0 from source 1.
    push1(1'b1, 3'd7, e);
    push1(1'b1, 3'd3, e);
    drain();
    expect_word(1'b1, 3'd4);
    expect_word(1'b1, 3'd0);
    verify_obs("wrap");

    // Mid-stream reset discards in-flight words at once.
    req0_valid = 1'b1; req0_data = 3'd4;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rstn = 1'b0; req0_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_id", out_id, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Fairness straight after release: grants alternate 0,1,...
    req0_valid = 1'b1; req0_data = 3'd0;
    req1_valid = 1'b1; req1_data = 3'd2;
    repeat (6) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    for (int i = 1; i < obs_cyc.size(); i++)
      chk($sformatf("fair_consecutive%0d", i), obs_cyc[i] - obs_cyc[0], i);
    for (int i = 0; i < 3; i++) begin
      expect_word(1'b0, 3'd5);
      expect_word(1'b1, 3'd7);
    end
    verify_obs("fair");

    // Backpressure: hold result 5 for 3 cycles.
    req0_valid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      req0_data = W'(d);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_data == 3'd5) begin found = 1'b1; break; end
    end
    chk("bp_seen", found, 1);
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 5);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    drain();
    for (int d = 5; d < 9; d++) expect_word(1'b0, W'(d));
    verify_obs("bp");

    // Lone requester with ptr=1: source 0 still streams at 1/cycle.
    push1(1'b0, 3'd1, e);
    req0_valid = 1'b1; acc = 0;
    for (int d = 0; d < 5; d++) begin
      req0_data = W'(d);
      @(negedge clk);
      chk("lone_ready", req0_ready, 1);
      @(posedge clk);
      if (req0_ready) acc++;
      #1;
    end
    req0_valid = 1'b0;
    chk("lone_throughput", acc, 5);
    drain();
    expect_word(1'b0, 3'd6);
    for (int d = 5; d < 10; d++) expect_word(1'b0, W'(d));
    verify_obs("lone");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inc_chain_arb.md
# inc_chain_arb

Two-requester front end for the 5-stage "+1 per stage" register chain used in the always-block studies. It arbitrates round-robin between two valid/ready sources and feeds one word per cycle into a stall-able pipeline. Each stage adds 1 modulo 2^W, and the result is presented on a valid/ready output tagged with the source id. It sits between the stimulus generators and the result checker in the playground benches.

## Interface
- W, 3, data width; all stage arithmetic is modulo 2^W
- STAGES, 5, number of pipeline stages (>=2); result = input + STAGES mod 2^W
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low (one clock; async active-low reset, fixed)
- req0_valid  in  1  source 0 has data
- req0_data  in  W  source 0 operand
- req0_ready  out  1  source 0 word accepted this cycle when both valid and ready are high
- req1_valid  in  1  source 1 has data
- req1_data  in  W  source 1 operand
- req1_ready  out  1  source 1 accept
- out_valid  out  1  result available
- out_data  out  W  result
- out_id  out  1  source of the result: 0 or 1
- out_ready  in  1  sink accepts result
- busy  out  1  any stage holds a valid word

## Operation
- Pipeline: STAGES register slots, each holding {valid, data[W], id}. Slot 0 captures the granted operand + 1. Slot k captures slot k-1 data + 1. Outputs come directly from slot STAGES-1.
- advance = !(out_valid && !out_ready). This is a global stall: when advance=0, every slot holds its contents.
- Arbitration uses a 1-bit priority pointer ptr, reset to 0.
  - req0_ready = advance && (ptr==0 || !req1_valid)
  - req1_ready = advance && (ptr==1 || !req0_valid)
  - Neither ready depends on its own valid. At most one handshake completes per cycle.
- On a handshake from source i: slot 0 loads {1, data_i+1, i} and ptr <= ~i. With no handshake and advance=1, slot 0 loads valid=0. ptr only changes on a handshake.
- Lone requester: it is granted every cycle regardless of ptr, giving back-to-back throughput of 1/cycle.
- Both requesters valid continuously: grants alternate 0,1,0,1,... when ptr=0.
- Bubbles propagate as valid=0 slots. Data and id of invalid slots are don't-care for output but must be deterministic after reset (all zero).
- Overflow: the +1 wraps modulo 2^W with no carry out and no flag.
- busy = OR of all slot valids.

## Timing
- Reset (rstn low, asynchronous): all slot valid/data/id <= 0 and ptr <= 0. Resulting outputs: out_valid=0, out_data=0, out_id=0, busy=0.
- Ready outputs are combinational. During reset, req0_ready = req1_ready = 1 if out_ready-independent advance=1 (out_valid=0). They must not be used for acceptance until rstn is released, because no capture occurs while rstn=0.
- Reset asserted mid-operation: all in-flight words are discarded immediately and no partial result is emitted. The first edge after release behaves as from power-up.
- Latency: a word accepted at rising edge E appears with out_valid=1 after edge E+STAGES-1, when there are no stalls. Each stall cycle adds one.
- Simultaneous handshake in and out: a word leaving slot STAGES-1 and a new word entering slot 0 on the same edge is legal.
- Stall with a bubble in the last slot: advance stays 1 because out_valid=0. Bubbles are not squeezed; the pipeline is a rigid shift.
- Asserting out_ready while out_valid=0 has no effect.

## Test plan
- Reset/idle: hold rstn=0 for 2 cycles mid-stream, then release -> out_valid=0, out_data=0, out_id=0, busy=0 immediately. No stale word ever appears.
- Single word: req0 sends 1 at edge E, out_ready=1 -> out_valid=1, out_data=6, out_id=0 after edge E+4, for exactly one cycle.
- Wrap: req1 sends 7 -> out_data=4, out_id=1. Also send 3 -> out_data=0.
- Fairness: both valid for 6 cycles from reset, data0=0, data1=2 -> outputs in order (id,data): (0,5),(1,7),(0,5),(1,7),(0,5),(1,7) on consecutive cycles.
- Backpressure: stream 0,1,2,3 from req0 and drop out_ready for 3 cycles while out_data=5 -> out_data holds 5 and both readies are 0 during the stall. Afterwards results 5,6,7,0 appear with no loss or duplication.
- Lone requester with ptr=1: req1 idle, req0 streams -> req0_ready=1 every cycle and throughput is 1/cycle.
